// File: rtl/sg_capture.sv
// Sink for the SG req/rdy/dat sample stream: a start pulse arms capture of
// CAPTURE_LEN samples into a FIFO that downstream logic drains on a read port.
module sg_capture #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int CAPTURE_LEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req,
    input  logic [DATA_W-1:0] dat,
    output logic              rdy,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [15:0]     LP_LAST  = 16'(CAPTURE_LEN - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [15:0]       r_count;
    logic [15:0]       r_stall;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              w_full;
    logic              w_empty;
    logic              w_clear;
    logic              w_wr;
    logic              w_rd;
    logic              w_last;

    assign w_full  = (r_level == LP_DEPTH);
    assign w_empty = (r_level == '0);
    // rdy depends on registered state only, so req never feeds back into rdy
    assign rdy     = (r_state == S_CAPTURE) && !w_full;
    assign w_clear = (r_state == S_IDLE) && start;
    assign w_wr    = req && rdy;
    assign w_rd    = rd_en && !w_empty && !w_clear;
    assign w_last  = w_wr && (r_count == LP_LAST);

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign empty     = w_empty;
    assign full      = w_full;
    assign level     = r_level;
    assign stall_cnt = r_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A new start discards whatever the previous capture left in the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_count  <= '0;
            r_stall  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_count  <= '0;
            r_stall  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 16'd1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if ((r_state == S_CAPTURE) && req && !rdy && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= dat;
        end
    end

endmodule
